// File: rtl/pmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmc_pkg
// Description : Shared types, default sizes and helpers for the
//               pattern_match_ctrl run controller and its window sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package pmc_pkg;

    localparam int MAXLEN_DEF = 8;
    localparam int CNTW_DEF   = 8;

    // Run controller states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A pattern length is usable when it is 1..maxlen bits
    function automatic logic len_legal(input logic [3:0] len, input int maxlen);
        return (len != 4'd0) && (int'(len) <= maxlen);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmc_window.sv
`default_nettype none
// ============================================================================
// Module      : pmc_window
// Description : Serial receive window, saturating fill count and pattern
//               compare for pattern_match_ctrl.
//   clk, res_n : clock, asynchronous active-low reset
//   a, a_valid : serial bit and its qualifier (already gated to RUN)
//   clr        : clears window and fill at the start of a run
//   len, pat   : active pattern length and pattern (pat[len-1] first bit)
//   ovl        : 1 = keep fill on match (overlapping), 0 = restart fill
//   match      : combinational, high when the bit being accepted completes
//                a match
// Revision    : 1.0 - initial release
// ============================================================================
module pmc_window
    import pmc_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              a,
    input  logic              a_valid,
    input  logic              clr,
    input  logic [3:0]        len,
    input  logic [MAXLEN-1:0] pat,
    input  logic              ovl,
    output logic              match
);

    localparam int FW = $clog2(MAXLEN + 1);
    localparam logic [FW-1:0] C_FILL_MAX = FW'(MAXLEN);

    logic [MAXLEN-1:0] r_win;
    logic [MAXLEN-1:0] w_win_next;
    logic [MAXLEN-1:0] w_mask;
    logic [FW-1:0]     r_fill;
    logic [FW-1:0]     w_fill_next;

    assign w_win_next  = {r_win[MAXLEN-2:0], a};
    assign w_fill_next = (r_fill == C_FILL_MAX) ? C_FILL_MAX : r_fill + FW'(1);

    // Only the low len bits of the window take part in the compare
    for (genvar i = 0; i < MAXLEN; i++) begin : g_mask
        assign w_mask[i] = (i < int'(len));
    end

    assign match = a_valid
                && (int'(w_fill_next) >= int'(len))
                && ((w_win_next & w_mask) == (pat & w_mask));

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (a_valid) begin
            r_win  <= w_win_next;
            // Non-overlapping mode must collect a fresh len bits after a hit
            r_fill <= (match && !ovl) ? '0 : w_fill_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pattern_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pattern_match_ctrl
// Description : Configurable serial bit-pattern detection run controller.
//               Shadowed configuration, IDLE/RUN/DONE sequencing, saturating
//               match counter with optional target stop.
//   clk, res_n            : clock, asynchronous active-low reset
//   cfg_we, cfg_pattern,
//   cfg_len, cfg_overlap,
//   cfg_target            : configuration, accepted in IDLE or DONE only
//   start, stop           : one-cycle run / abort requests
//   a, a_valid            : qualified serial input
//   busy, done            : state levels (RUN, DONE)
//   hit                   : registered one-cycle match pulse
//   match_cnt             : matches in the current or last run
//   err                   : one-cycle pulse on start with illegal length
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_match_ctrl
    import pmc_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_target,
    input  logic              start,
    input  logic              stop,
    input  logic              a,
    input  logic              a_valid,
    output logic              busy,
    output logic              hit,
    output logic [CNTW-1:0]   match_cnt,
    output logic              done,
    output logic              err
);

    localparam logic [CNTW-1:0] C_CNT_MAX = '1;

    state_t            r_state;
    state_t            w_state_next;
    logic [MAXLEN-1:0] r_pat;
    logic [3:0]        r_len;
    logic              r_ovl;
    logic [CNTW-1:0]   r_tgt;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_cnt_next;
    logic              r_hit;
    logic              r_err;
    logic              w_hit_next;
    logic              w_err_next;
    logic              w_run;
    logic              w_cfg_open;
    logic              w_len_ok;
    logic              w_launch;
    logic              w_match;

    assign w_run      = (r_state == RUN);
    assign w_cfg_open = (r_state == IDLE) || (r_state == DONE);
    assign w_len_ok   = len_legal(r_len, MAXLEN);
    // A new run begins; stop takes precedence over start
    assign w_launch   = w_cfg_open && start && !stop && w_len_ok;

    pmc_window #(
        .MAXLEN (MAXLEN)
    ) u_window (
        .clk     (clk),
        .res_n   (res_n),
        .a       (a),
        .a_valid (a_valid & w_run),
        .clr     (w_launch),
        .len     (r_len),
        .pat     (r_pat),
        .ovl     (r_ovl),
        .match   (w_match)
    );

    // Shadow configuration
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_pat <= '0;
            r_len <= 4'd1;
            r_ovl <= 1'b1;
            r_tgt <= '0;
        end else if (cfg_we && w_cfg_open) begin
            r_pat <= cfg_pattern;
            r_len <= cfg_len;
            r_ovl <= cfg_overlap;
            r_tgt <= cfg_target;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hit   <= w_hit_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hit_next   = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (stop) begin
                    w_state_next = IDLE;
                end else if (start) begin
                    if (w_len_ok) begin
                        w_state_next = RUN;
                        w_cnt_next   = '0;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            RUN: begin
                // A match is always counted, even when stop arrives with it
                if (w_match) begin
                    w_hit_next = 1'b1;
                    if (r_cnt != C_CNT_MAX) begin
                        w_cnt_next = r_cnt + CNTW'(1);
                    end
                end
                if (stop) begin
                    w_state_next = IDLE;
                end else if (w_match && (r_tgt != '0) && (w_cnt_next == r_tgt)) begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign busy      = w_run;
    assign done      = (r_state == DONE);
    assign hit       = r_hit;
    assign err       = r_err;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pattern_match_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pattern_match_ctrl
// Description : Self-checking bench for pattern_match_ctrl: table of fixed
//               runs, hand sequences for corner cases, randomized runs
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_match_ctrl;

    localparam int MAXLEN = 8;
    localparam int CNTW   = 8;

    logic             clk = 1'b0;
    logic             res_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [7:0]       cfg_pattern = '0;
    logic [3:0]       cfg_len = 4'd1;
    logic             cfg_overlap = 1'b1;
    logic [7:0]       cfg_target = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             a = 1'b0;
    logic             a_valid = 1'b0;
    logic             busy, hit, done, err;
    logic [CNTW-1:0]  match_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pattern_match_ctrl #(
        .MAXLEN (MAXLEN),
        .CNTW   (CNTW)
    ) dut (
        .clk         (clk),
        .res_n       (res_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .stop        (stop),
        .a           (a),
        .a_valid     (a_valid),
        .busy        (busy),
        .hit         (hit),
        .match_cnt   (match_cnt),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic        ovl;
        logic [7:0]  tgt;
        int          nbits;
        logic [15:0] bits;   // first bit sent is bits[nbits-1]
        logic [15:0] hits;   // expected hit after each bit, same order
        int          cnt;
        logic        dn;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic send(input logic b, input logic v);
        a = b; a_valid = v; tick(); a_valid = 1'b0;
    endtask

    // Reference model state
    bit   hist[$];
    int   m_fill, m_cnt;
    bit   m_run, m_done;

    initial begin
        int hit_total;
        int last_hit;
        bit v, b, exp_hit, mm;
        logic [7:0] rp, rt;
        logic [3:0] rl;
        logic ro;

        tbl[0] = '{8'b1011, 4'd4, 1'b1, 8'd0, 7,  16'b1011011,          16'b0001001,          2, 1'b0};
        tbl[1] = '{8'b1011, 4'd4, 1'b0, 8'd0, 7,  16'b1011011,          16'b0001000,          1, 1'b0};
        tbl[2] = '{8'b11,   4'd2, 1'b1, 8'd3, 5,  16'b11111,            16'b01110,            3, 1'b1};
        tbl[3] = '{8'hAA,   4'd8, 1'b0, 8'd0, 16, 16'b1010101010101010, 16'b0000000100000001, 2, 1'b0};
        tbl[4] = '{8'b1,    4'd1, 1'b0, 8'd0, 4,  16'b1011,             16'b1011,             3, 1'b0};

        // Reset state
        tick(); tick();
        check("reset busy", busy, 0);
        check("reset hit", hit, 0);
        check("reset cnt", match_cnt, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        @(negedge clk); res_n = 1'b1;
        tick();

        // Table-driven runs
        for (int t = 0; t < 5; t++) begin
            configure(tbl[t].pat, tbl[t].len, tbl[t].ovl, tbl[t].tgt);
            do_start();
            check($sformatf("tbl%0d busy after start", t), busy, 1);
            last_hit = 0;
            for (int i = 0; i < tbl[t].nbits; i++)
                if (tbl[t].hits[tbl[t].nbits-1-i]) last_hit = i;
            for (int i = 0; i < tbl[t].nbits; i++) begin
                send(tbl[t].bits[tbl[t].nbits-1-i], 1'b1);
                check($sformatf("tbl%0d hit bit%0d", t, i+1), hit, tbl[t].hits[tbl[t].nbits-1-i]);
                check($sformatf("tbl%0d done bit%0d", t, i+1), done, tbl[t].dn && (i >= last_hit));
                check($sformatf("tbl%0d busy bit%0d", t, i+1), busy, !(tbl[t].dn && (i >= last_hit)));
            end
            check($sformatf("tbl%0d cnt", t), match_cnt, tbl[t].cnt);
            do_stop();
            check($sformatf("tbl%0d idle busy", t), busy, 0);
            check($sformatf("tbl%0d idle done", t), done, 0);
            check($sformatf("tbl%0d cnt kept", t), match_cnt, tbl[t].cnt);
        end

        // Illegal lengths
        configure(8'b1011, 4'd0, 1'b1, 8'd0);
        do_start();
        check("len0 err", err, 1);
        check("len0 busy", busy, 0);
        tick();
        check("len0 err pulse", err, 0);
        configure(8'b1011, 4'd9, 1'b1, 8'd0);
        do_start();
        check("len9 err", err, 1);
        check("len9 busy", busy, 0);
        tick();
        check("len9 err pulse", err, 0);

        // start and stop together: stop wins
        configure(8'b1011, 4'd4, 1'b1, 8'd0);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("start+stop busy", busy, 0);

        // Gaps between valid bits
        do_start();
        hit_total = 0;
        for (int i = 0; i < 4; i++) begin
            b = (i != 1);
            send(b, 1'b1);
            if (hit) hit_total++;
            send(!b, 1'b0);
            if (hit) hit_total++;
            send(b, 1'b0);
            if (hit) hit_total++;
        end
        check("gap hits", hit_total, 1);
        check("gap cnt", match_cnt, 1);
        do_stop();

        // Config write during RUN is ignored
        do_start();
        configure(8'b00, 4'd2, 1'b1, 8'd0);
        hit_total = 0;
        send(1, 1); if (hit) hit_total++;
        send(0, 1); if (hit) hit_total++;
        send(0, 1); if (hit) hit_total++;
        send(1, 1); if (hit) hit_total++;
        send(0, 1); if (hit) hit_total++;
        send(1, 1); if (hit) hit_total++;
        send(1, 1);
        check("lockout last hit", hit, 1);
        if (hit) hit_total++;
        check("lockout hits", hit_total, 1);
        do_stop();

        // start in RUN does not clear the count
        do_start();
        send(1, 1); send(0, 1); send(1, 1); send(1, 1);
        do_start();
        check("restart ignored cnt", match_cnt, 1);
        check("restart ignored busy", busy, 1);

        // stop coincident with a match bit
        send(0, 1); send(1, 1);
        a = 1'b1; a_valid = 1'b1; stop = 1'b1;
        tick();
        a_valid = 1'b0; stop = 1'b0;
        check("stop+match hit", hit, 1);
        check("stop+match cnt", match_cnt, 2);
        check("stop+match busy", busy, 0);
        tick();
        check("stop+match hit pulse", hit, 0);
        check("stop+match cnt kept", match_cnt, 2);

        // Counter saturation with unlimited target
        configure(8'b1, 4'd1, 1'b1, 8'd0);
        do_start();
        for (int i = 0; i < 260; i++) send(1, 1);
        check("sat cnt", match_cnt, 255);
        check("sat busy", busy, 1);
        check("sat hit", hit, 1);

        // Asynchronous reset mid-run, then shadow reset values
        #2 res_n = 1'b0;
        #1;
        check("areset busy", busy, 0);
        check("areset hit", hit, 0);
        check("areset cnt", match_cnt, 0);
        check("areset done", done, 0);
        @(negedge clk); res_n = 1'b1;
        tick();
        do_start();
        send(0, 1);
        check("shadow reset hit0", hit, 1);
        send(1, 1);
        check("shadow reset hit1", hit, 0);
        check("shadow reset cnt", match_cnt, 1);
        do_stop();

        // Randomized runs against the reference model
        for (int r = 0; r < 30; r++) begin
            rl = 4'($urandom_range(1, 6));
            rp = 8'($urandom_range(0, 255));
            ro = 1'($urandom_range(0, 1));
            rt = 8'($urandom_range(0, 5));
            configure(rp, rl, ro, rt);
            do_start();
            hist.delete();
            m_fill = 0; m_cnt = 0; m_run = 1; m_done = 0;
            for (int c = 0; c < 40; c++) begin
                v = ($urandom_range(0, 3) != 0);
                b = 1'($urandom_range(0, 1));
                start = m_run && ($urandom_range(0, 19) == 0);
                send(b, v);
                start = 1'b0;
                exp_hit = 0;
                if (m_run && v) begin
                    hist.push_back(b);
                    if (m_fill < MAXLEN) m_fill++;
                    mm = (m_fill >= int'(rl));
                    if (mm)
                        for (int k = 0; k < int'(rl); k++)
                            if (hist[hist.size()-1-k] != rp[k]) mm = 0;
                    if (mm) begin
                        exp_hit = 1;
                        if (m_cnt < 255) m_cnt++;
                        if (!ro) m_fill = 0;
                        if (rt != 0 && m_cnt == int'(rt)) begin
                            m_run = 0; m_done = 1;
                        end
                    end
                end
                check($sformatf("rnd%0d c%0d hit", r, c), hit, exp_hit);
                check($sformatf("rnd%0d c%0d cnt", r, c), match_cnt, m_cnt);
                check($sformatf("rnd%0d c%0d busy", r, c), busy, m_run);
                check($sformatf("rnd%0d c%0d done", r, c), done, m_done);
            end
            do_stop();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pattern_match_ctrl.md
# pattern_match_ctrl

Run controller for serial bit-pattern detection. Holds a programmable pattern of 1 to MAXLEN bits, arms on a start request, scans a qualified serial stream in overlapping or non-overlapping mode, counts matches, and stops on a target count or an explicit stop. It sits between a register or config master and a serial input. It replaces fixed-pattern detector FSMs with one configurable, sequenced unit.

## Interface
- MAXLEN, 8: maximum pattern length in bits.
- CNTW, 8: match counter width.

- clk  in  1  clock, rising edge.
- res_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe; honoured only in IDLE or DONE.
- cfg_pattern  in  MAXLEN  pattern; bit [len-1] is the first bit received.
- cfg_len  in  4  pattern length; legal range 1..MAXLEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  in  CNTW  match count that ends the run; 0 = unlimited.
- start  in  1  one-cycle run request.
- stop  in  1  one-cycle abort request.
- a  in  1  serial data bit.
- a_valid  in  1  qualifies a; a is ignored when low.
- busy  out  1  high in RUN.
- hit  out  1  one-cycle registered match pulse.
- match_cnt  out  CNTW  matches in the current or last run.
- done  out  1  level; high in DONE.
- err  out  1  one-cycle pulse on start with illegal cfg_len.

## Operation
- States: IDLE, RUN, DONE. Encoding is 2 bits.
- Shadow registers pat, len, ovl and tgt load on cfg_we in IDLE or DONE. cfg_we in RUN is ignored.
- Matching datapath:
  - win is a MAXLEN shift register; fill is a saturating count of valid bits received, 0..MAXLEN.
  - Each a_valid cycle in RUN does win <= {win[MAXLEN-2:0], a}.
  - Match condition: fill_next >= len and win_next[len-1:0] == pat[len-1:0].
- On a match:
  - If ovl = 1, the window is retained.
  - If ovl = 0, fill clears to 0.
- IDLE to RUN:
  - Requires start with len in 1..MAXLEN.
  - match_cnt, fill and win clear.
- IDLE with start and illegal len: pulse err, stay in IDLE.
- RUN to DONE: when a match makes match_cnt_next == tgt and tgt != 0.
- RUN to IDLE: on stop. match_cnt is retained.
- DONE to RUN: on start with legal len, with the same clears as IDLE to RUN.
- DONE to IDLE: on stop.
- match_cnt saturates at 2^CNTW-1. With tgt = 0 the run continues after saturation.
- Simultaneous events:
  - A match and stop in the same cycle: the match is counted and hit pulses; stop wins the state transition.
  - start and stop in the same cycle: stop wins.
  - start in RUN is ignored.

## Timing
- Reset values: state IDLE, busy 0, hit 0, match_cnt 0, done 0, err 0, win 0, fill 0. Shadow registers reset to pat 0, len 1, ovl 1, tgt 0.
- Reset asserted mid-run forces all of the above immediately, asynchronously.
- start at edge N gives busy = 1 after edge N. The first bit sampled is at edge N+1.
- A match bit sampled at edge M gives hit = 1 and updated match_cnt after edge M, both visible in cycle M+1.
- done rises in the same cycle as the final hit. busy falls in that cycle.
- err is visible in the cycle after start.
- hit never asserts outside the cycle following a RUN-state match.
- Bits presented with a_valid = 0 do not shift, count or reset fill.

## Structure
- Shared package pmc_pkg holds:
  - the state typedef with IDLE, RUN and DONE;
  - MAXLEN_DEF and CNTW_DEF;
  - the length-legality function.
- One sub-module, pmc_window, holds win, fill and match comparison. It takes a, a_valid, clr, len, pat and ovl, and outputs match.
- The FSM, shadow registers and counter live in the top level.

## Test plan
- Overlap run: pat 1011, len 4, ovl 1, tgt 0. Stream 1,0,1,1,0,1,1 -> hit after bits 4 and 7, match_cnt = 2.
- Non-overlap run: same stream with ovl 0 -> single hit after bit 4, match_cnt = 1.
- Target stop: pat 11, len 2, ovl 1, tgt 3. Stream 1,1,1,1,1 -> hits after bits 2, 3 and 4. done = 1 and busy = 0 in the cycle of the third hit. Bit 5 is ignored and match_cnt stays 3.
- Illegal length: len 0 with start -> err pulse, state stays IDLE, busy stays 0. Same result for len 9.
- Gaps and config lockout:
  - Stream 1011 with a_valid low between bits -> still 1 hit.
  - cfg_we during RUN changing pat has no effect.
- Abort and reset:
  - stop coincident with a match bit -> hit = 1, match_cnt increments, next state IDLE.
  - res_n low mid-run -> all outputs 0 immediately, state IDLE.
